// File: rtl/decode_regfile_if.sv
// Handshake and writeback bundle between the fetch side, the decode/regfile stage and the ALU.
// slave is the stage's view; master is the view of whatever drives it.
interface decode_regfile_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;

  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [31:0] ex_imm;
  logic [3:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic        ex_sel;
  logic [4:0]  ex_rd;

  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        illegal;

  modport slave (
    input  in_valid, instr, ex_ready, wb_en, wb_addr, wb_data,
    output in_ready, ex_valid, ex_rs1, ex_rs2, ex_imm, ex_funct3,
           ex_funct7, ex_sel, ex_rd, illegal
  );

  modport master (
    output in_valid, instr, ex_ready, wb_en, wb_addr, wb_data,
    input  in_ready, ex_valid, ex_rs1, ex_rs2, ex_imm, ex_funct3,
           ex_funct7, ex_sel, ex_rd, illegal
  );
endinterface

// File: rtl/decode_regfile.sv
// Decode/operand-fetch stage for R-type and I-type ALU instructions with a 32x32 register file,
// writeback bypass and in-place operand refresh while the ALU stalls.
module decode_regfile (
  input  logic             clk,
  input  logic             rst,
  decode_regfile_if.slave  bus
);

  localparam logic [6:0] OPCODE_R = 7'b0110011;
  localparam logic [6:0] OPCODE_I = 7'b0010011;

  logic [31:0] rf [32];

  logic        ex_valid_q;
  logic        illegal_q;
  logic [31:0] ex_rs1_q;
  logic [31:0] ex_rs2_q;
  logic [31:0] ex_imm_q;
  logic [3:0]  ex_funct3_q;
  logic [6:0]  ex_funct7_q;
  logic        ex_sel_q;
  logic [4:0]  ex_rd_q;

  logic [4:0]  held_rs1;
  logic [4:0]  held_rs2;
  logic        held_rs2_used;

  logic        accept;
  logic        is_r;
  logic        is_i;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        wb_write;

  assign bus.in_ready = !ex_valid_q || bus.ex_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  assign is_r     = (bus.instr[6:0] == OPCODE_R);
  assign is_i     = (bus.instr[6:0] == OPCODE_I);
  assign rs1_idx  = bus.instr[19:15];
  assign rs2_idx  = bus.instr[24:20];
  assign wb_write = bus.wb_en && (bus.wb_addr != 5'd0);

  // A write landing in the same cycle as the read must win over the stale array value.
  always_comb begin
    rs1_val = 32'd0;
    rs2_val = 32'd0;
    if (rs1_idx != 5'd0)
      rs1_val = (wb_write && bus.wb_addr == rs1_idx) ? bus.wb_data : rf[rs1_idx];
    if (rs2_idx != 5'd0)
      rs2_val = (wb_write && bus.wb_addr == rs2_idx) ? bus.wb_data : rf[rs2_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= 32'd0;
      ex_valid_q    <= 1'b0;
      illegal_q     <= 1'b0;
      ex_rs1_q      <= 32'd0;
      ex_rs2_q      <= 32'd0;
      ex_imm_q      <= 32'd0;
      ex_funct3_q   <= 4'd0;
      ex_funct7_q   <= 7'd0;
      ex_sel_q      <= 1'b0;
      ex_rd_q       <= 5'd0;
      held_rs1      <= 5'd0;
      held_rs2      <= 5'd0;
      held_rs2_used <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      if (wb_write)
        rf[bus.wb_addr] <= bus.wb_data;

      if (accept) begin
        if (is_r || is_i) begin
          ex_valid_q    <= 1'b1;
          ex_rs1_q      <= rs1_val;
          ex_rs2_q      <= is_r ? rs2_val : 32'd0;
          ex_imm_q      <= is_i ? {{20{bus.instr[31]}}, bus.instr[31:20]} : 32'd0;
          ex_funct3_q   <= {1'b0, bus.instr[14:12]};
          ex_funct7_q   <= is_r ? bus.instr[31:25] : 7'd0;
          ex_sel_q      <= is_r;
          ex_rd_q       <= bus.instr[11:7];
          held_rs1      <= rs1_idx;
          held_rs2      <= rs2_idx;
          held_rs2_used <= is_r;
        end else begin
          // in_ready implies the old output was empty or consumed, so it always empties here.
          illegal_q  <= 1'b1;
          ex_valid_q <= 1'b0;
        end
      end else if (ex_valid_q && bus.ex_ready) begin
        ex_valid_q <= 1'b0;
      end else if (ex_valid_q) begin
        if (wb_write && bus.wb_addr == held_rs1)
          ex_rs1_q <= bus.wb_data;
        if (wb_write && held_rs2_used && bus.wb_addr == held_rs2)
          ex_rs2_q <= bus.wb_data;
      end
    end
  end

  assign bus.ex_valid  = ex_valid_q;
  assign bus.illegal   = illegal_q;
  assign bus.ex_rs1    = ex_rs1_q;
  assign bus.ex_rs2    = ex_rs2_q;
  assign bus.ex_imm    = ex_imm_q;
  assign bus.ex_funct3 = ex_funct3_q;
  assign bus.ex_funct7 = ex_funct7_q;
  assign bus.ex_sel    = ex_sel_q;
  assign bus.ex_rd     = ex_rd_q;

endmodule

// File: doc/decode_regfile.md
# decode_regfile

Decode and operand-fetch stage that sits directly upstream of the integer ALU. It accepts one 32-bit instruction per cycle over a valid/ready handshake and decodes R-type (opcode 7'b0110011) and I-type ALU (opcode 7'b0010011) instructions. It reads the 32×32 register file and presents registered operands, immediate, funct fields and the R/I select to the ALU. Writeback into the register file enters through a separate write port, with same-cycle bypass and in-place refresh of a stalled output.

## Interface
- No parameters. XLEN is fixed at 32 and the register count is fixed at 32.

- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instr holds a valid instruction
- in_ready  out  1  stage can accept an instruction this cycle
- instr  in  32  raw instruction word
- ex_valid  out  1  the ex_* outputs hold a decoded instruction
- ex_ready  in  1  ALU consumes the output this cycle
- ex_rs1  out  32  rs1 operand value
- ex_rs2  out  32  rs2 operand value; 0 for I-type
- ex_imm  out  32  sign-extended instr[31:20] for I-type; 0 for R-type
- ex_funct3  out  4  {1'b0, instr[14:12]}
- ex_funct7  out  7  instr[31:25] for R-type; 0 for I-type
- ex_sel  out  1  1 = R-type (alu_r), 0 = I-type (alu_i)
- ex_rd  out  5  destination register, instr[11:7]
- wb_en  in  1  register-file write enable
- wb_addr  in  5  write address
- wb_data  in  32  write data
- illegal  out  1  one-cycle pulse: an unsupported opcode was accepted

## Operation
- Accept condition: in_valid && in_ready.
- in_ready = !ex_valid || ex_ready. This is combinational, and no other input may affect it.
- Legal accept: on the next edge, load all ex_* fields and set ex_valid = 1.
- Illegal accept (any other opcode):
  - The instruction is consumed and dropped.
  - illegal = 1 for exactly the next cycle.
  - ex_valid is cleared if it was being consumed; otherwise it is unchanged.
- Output consumed with no new accept: ex_valid drops to 0 on the next edge. The ex_* data may stay stale.
- Stall (ex_valid && !ex_ready): every ex_* field holds, with one exception. A wb write with wb_addr != 0 that matches the held rs1 or rs2 index replaces ex_rs1 or ex_rs2 with wb_data. This is why the stage keeps the rs1/rs2 indices internally.
- Register file:
  - Writes when wb_en && wb_addr != 0.
  - x0 always reads 0, and writes to x0 are ignored.
- Read bypass: if the wb write address equals a source index (nonzero) in the same cycle as the accept, the operand takes wb_data, not the old array value.
- Operand and field values by type:
  - R-type: rs1 = instr[19:15], rs2 = instr[24:20], funct7 passed through.
  - I-type: ex_rs2 = 0, ex_funct7 = 0. The rs2 index is marked unused, so a stall refresh never touches ex_rs2.
  - funct7 is not checked here; the ALU handles legality.

## Timing
- Latency: accept at edge N gives ex_valid and data valid after edge N, i.e. usable in cycle N+1.
- Throughput: one instruction per cycle while ex_ready = 1.
- Register-file writes are visible to a read in the same cycle through the bypass, and to any later read directly.
- Reset (synchronous):
  - All 32 registers clear to 0.
  - ex_valid = 0, illegal = 0, and every ex_* data output = 0.
  - While rst is high, in_ready = 1, but nothing is accepted.
- Reset during a stall discards the held instruction. A wb write in the reset cycle is ignored.
- Simultaneous events:
  - Consume plus accept in the same cycle: the new instruction replaces the old one, and ex_valid stays 1.
  - A wb write and an accept of an instruction reading the same register: the bypass applies.

## Test plan
- Reset, then write x5 = 0x0000_0010 and x6 = 0x0000_0003, then issue `sub x7,x5,x6` (0x40628_3B3) with ex_ready = 1 → next cycle: ex_valid = 1, ex_rs1 = 0x10, ex_rs2 = 0x3, ex_funct7 = 0x20, ex_funct3 = 0, ex_sel = 1, ex_rd = 7.
- `addi x1,x0,-1` (0xFFF0_0093) → ex_rs1 = 0, ex_imm = 0xFFFF_FFFF, ex_rs2 = 0, ex_sel = 0, ex_funct3 = 0.
- Same-cycle bypass: wb x5 = 0xDEAD_BEEF in the accept cycle of `add x1,x5,x5` → ex_rs1 = ex_rs2 = 0xDEAD_BEEF.
- Stall refresh: hold ex_ready = 0 with `add x1,x5,x6` outstanding, then wb x6 = 0x1234 → ex_rs2 becomes 0x1234 and ex_rs1 is unchanged. While stalled, in_ready = 0 and a presented instruction is not consumed.
- Back-to-back: 4 instructions with ex_ready held at 1 → 4 consecutive ex_valid cycles, in order, with no bubbles. A wb to x0 with data 0x55 → a later read of x0 returns 0.
- Illegal opcode 0x0000_0003 (load) → illegal pulses for one cycle and ex_valid stays 0. Asserting rst during a stall → ex_valid = 0 on the next edge, and every register reads 0.
